// File: rtl/iob2axi_rd_if.sv
// Bundle of control, AXI-4 read channel and native write port signals for iob2axi_rd.
// The master modport is the engine's view; slave is the surrounding system's view.
interface iob2axi_rd_if #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned AXI_ADDR_W = ADDR_W,
  parameter int unsigned AXI_DATA_W = DATA_W,
  parameter int unsigned AXI_ID_W   = 1,
  parameter int unsigned AXI_LEN_W  = 8
);
  localparam int unsigned AXI_SIZE_W  = 3;
  localparam int unsigned AXI_BURST_W = 2;
  localparam int unsigned AXI_RESP_W  = 2;
  localparam int unsigned STRB_W      = DATA_W / 8;

  // control
  logic                   run;
  logic [ADDR_W-1:0]      addr;
  logic [AXI_LEN_W-1:0]   length;
  logic                   ready;
  logic                   error;
  // AXI read address channel
  logic [AXI_ID_W-1:0]    m_axi_arid;
  logic [AXI_ADDR_W-1:0]  m_axi_araddr;
  logic [AXI_LEN_W-1:0]   m_axi_arlen;
  logic [AXI_SIZE_W-1:0]  m_axi_arsize;
  logic [AXI_BURST_W-1:0] m_axi_arburst;
  logic                   m_axi_arlock;
  logic [3:0]             m_axi_arcache;
  logic [2:0]             m_axi_arprot;
  logic [3:0]             m_axi_arqos;
  logic                   m_axi_arvalid;
  logic                   m_axi_arready;
  // AXI read data channel
  logic [AXI_ID_W-1:0]    m_axi_rid;
  logic [AXI_DATA_W-1:0]  m_axi_rdata;
  logic [AXI_RESP_W-1:0]  m_axi_rresp;
  logic                   m_axi_rlast;
  logic                   m_axi_rvalid;
  logic                   m_axi_rready;
  // native write port
  logic                   m_valid;
  logic [ADDR_W-1:0]      m_addr;
  logic [DATA_W-1:0]      m_wdata;
  logic [STRB_W-1:0]      m_wstrb;
  logic                   m_ready;

  modport master (
    input  run, addr, length,
    output ready, error,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output m_valid, m_addr, m_wdata, m_wstrb,
    input  m_ready
  );

  modport slave (
    output run, addr, length,
    input  ready, error,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  m_valid, m_addr, m_wdata, m_wstrb,
    output m_ready
  );
endinterface

// File: rtl/iob2axi_rd.sv
// AXI-4 read-burst master: one INCR burst per run pulse, each returned beat is
// forwarded combinationally to a native write port at consecutive word addresses.
module iob2axi_rd #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned AXI_ADDR_W = ADDR_W,
  parameter int unsigned AXI_DATA_W = DATA_W,
  parameter int unsigned AXI_ID_W   = 1,
  parameter int unsigned AXI_LEN_W  = 8
) (
  input logic          clk,
  input logic          rst_n,
  iob2axi_rd_if.master bus
);
  localparam int unsigned AXI_SIZE_W  = 3;
  localparam int unsigned AXI_BURST_W = 2;
  localparam int unsigned STRB_W      = DATA_W / 8;
  localparam int unsigned SIZE        = $clog2(DATA_W / 8);
  localparam int unsigned CNT_W       = AXI_LEN_W + 1;

  typedef enum logic [1:0] {IDLE, ADDR_HS, READ} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [AXI_LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               overrun_c, beat_c, rready_c, m_valid_c;
  logic               unused_c;

  // state and burst context registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // next-state and data-channel handshake
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rready_c  = 1'b0;
    m_valid_c = 1'b0;
    beat_c    = 1'b0;
    overrun_c = cnt_q > CNT_W'(len_q);
    case (state_q)
      IDLE: begin
        if (bus.run) begin
          addr_d  = bus.addr;
          len_d   = bus.length;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ADDR_HS;
        end
      end
      ADDR_HS: begin
        if (bus.m_axi_arready) state_d = READ;
      end
      READ: begin
        // beats past arlen are swallowed so the slave can still reach rlast
        m_valid_c = bus.m_axi_rvalid & ~overrun_c;
        rready_c  = bus.m_ready | overrun_c;
        beat_c    = bus.m_axi_rvalid & rready_c;
        if (beat_c) begin
          // counter saturates at length+1 so the overrun flag cannot wrap away
          if (!overrun_c) cnt_d = cnt_q + CNT_W'(1);
          err_d = err_q | (|bus.m_axi_rresp) | overrun_c;
          if (bus.m_axi_rlast) begin
            state_d = IDLE;
            if (cnt_q != CNT_W'(len_q)) err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready         = (state_q == IDLE);
  assign bus.error         = err_q;
  assign bus.m_axi_arid    = '0;
  assign bus.m_axi_araddr  = AXI_ADDR_W'(addr_q);
  assign bus.m_axi_arlen   = len_q;
  assign bus.m_axi_arsize  = AXI_SIZE_W'(SIZE);
  assign bus.m_axi_arburst = AXI_BURST_W'(1);
  assign bus.m_axi_arlock  = 1'b0;
  assign bus.m_axi_arcache = 4'd2;
  assign bus.m_axi_arprot  = 3'd2;
  assign bus.m_axi_arqos   = 4'd0;
  assign bus.m_axi_arvalid = (state_q == ADDR_HS);
  assign bus.m_axi_rready  = rready_c;
  assign bus.m_valid       = m_valid_c;
  assign bus.m_addr        = addr_q + (ADDR_W'(cnt_q) << SIZE);
  assign bus.m_wdata       = DATA_W'(bus.m_axi_rdata);
  assign bus.m_wstrb       = {STRB_W{m_valid_c}};

  assign unused_c = ^bus.m_axi_rid;
endmodule

// File: tb/tb_iob2axi_rd.sv
// Directed bench for iob2axi_rd: drives AR/R and native ready, checks every
// handshake cycle against hand-computed addresses, data and status.
module tb_iob2axi_rd;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   wr_cnt = 0;
  int   wr_base = 0;

  iob2axi_rd_if #(.ADDR_W(32), .DATA_W(32), .AXI_ID_W(1), .AXI_LEN_W(8)) bus ();

  iob2axi_rd #(.ADDR_W(32), .DATA_W(32), .AXI_ID_W(1), .AXI_LEN_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.m_valid && bus.m_ready) wr_cnt <= wr_cnt + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input string tag, input logic [31:0] a, input logic [7:0] l,
                             input int delay);
    bus.addr = a; bus.length = l; bus.run = 1'b1;
    @(negedge clk);
    chk({tag, "_rdy_idle"}, bus.ready, 1);
    step();
    bus.run = 1'b0; bus.addr = 32'hDEAD_BEEF; bus.length = 8'hFF;
    wr_base = wr_cnt;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk($sformatf("%s_arv_wait%0d", tag, i), bus.m_axi_arvalid, 1);
      chk($sformatf("%s_araddr_wait%0d", tag, i), bus.m_axi_araddr, a);
      step();
    end
    bus.m_axi_arready = 1'b1;
    @(negedge clk);
    chk({tag, "_arvalid"}, bus.m_axi_arvalid, 1);
    chk({tag, "_araddr"}, bus.m_axi_araddr, a);
    chk({tag, "_arlen"}, bus.m_axi_arlen, l);
    chk({tag, "_busy"}, bus.ready, 0);
    chk({tag, "_err_clr"}, bus.error, 0);
    step();
    bus.m_axi_arready = 1'b0;
  endtask

  task automatic beat(input string tag, input logic v, input logic [31:0] d, input logic [1:0] resp,
                      input logic last, input logic mr, input logic exp_mv,
                      input logic [31:0] exp_addr, input logic exp_rr);
    bus.m_axi_rvalid = v; bus.m_axi_rdata = d; bus.m_axi_rresp = resp;
    bus.m_axi_rlast = last; bus.m_ready = mr;
    @(negedge clk);
    chk({tag, "_mvalid"}, bus.m_valid, exp_mv);
    chk({tag, "_rready"}, bus.m_axi_rready, exp_rr);
    if (exp_mv) begin
      chk({tag, "_maddr"}, bus.m_addr, exp_addr);
      chk({tag, "_wdata"}, bus.m_wdata, d);
      chk({tag, "_wstrb"}, bus.m_wstrb, 4'hF);
    end else begin
      chk({tag, "_wstrb0"}, bus.m_wstrb, 4'h0);
    end
    step();
  endtask

  task automatic end_burst(input string tag, input logic exp_err, input int exp_wr);
    bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0; bus.m_axi_rresp = 2'b00; bus.m_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_ready"}, bus.ready, 1);
    chk({tag, "_error"}, bus.error, exp_err);
    chk({tag, "_writes"}, 64'(wr_cnt - wr_base), 64'(exp_wr));
    chk({tag, "_arv_idle"}, bus.m_axi_arvalid, 0);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.run = 1'b0; bus.addr = '0; bus.length = '0;
    bus.m_axi_arready = 1'b0; bus.m_axi_rid = '0; bus.m_axi_rdata = '0;
    bus.m_axi_rresp = '0; bus.m_axi_rlast = 1'b0; bus.m_axi_rvalid = 1'b0; bus.m_ready = 1'b0;
    #2;
    chk("rst_ready", bus.ready, 1);
    chk("rst_error", bus.error, 0);
    chk("rst_arvalid", bus.m_axi_arvalid, 0);
    chk("rst_rready", bus.m_axi_rready, 0);
    chk("rst_mvalid", bus.m_valid, 0);
    chk("rst_araddr", bus.m_axi_araddr, 0);
    chk("const_arsize", bus.m_axi_arsize, 3'd2);
    chk("const_arburst", bus.m_axi_arburst, 2'd1);
    chk("const_cache_prot", {bus.m_axi_arcache, bus.m_axi_arprot}, {4'd2, 3'd2});
    chk("const_id_lock_qos", {bus.m_axi_arid, bus.m_axi_arlock, bus.m_axi_arqos}, 6'd0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // 1: basic 4-beat burst, no backpressure
    start_burst("t1", 32'h100, 8'd3, 0);
    for (int i = 0; i < 4; i++)
      beat($sformatf("t1_b%0d", i), 1, 32'hA000 + 32'(i), 2'b00, i == 3, 1, 1, 32'h100 + 32'(4 * i), 1);
    end_burst("t1", 0, 4);

    // 2: native backpressure and R gaps
    start_burst("t2", 32'h100, 8'd3, 0);
    beat("t2a", 1, 32'hB000, 2'b00, 0, 0, 1, 32'h100, 0);
    beat("t2b", 1, 32'hB000, 2'b00, 0, 1, 1, 32'h100, 1);
    beat("t2c", 0, 32'h0,    2'b00, 0, 1, 0, 32'h0,   1);
    beat("t2d", 1, 32'hB001, 2'b00, 0, 0, 1, 32'h104, 0);
    beat("t2e", 1, 32'hB001, 2'b00, 0, 1, 1, 32'h104, 1);
    beat("t2f", 0, 32'h0,    2'b00, 0, 0, 0, 32'h0,   0);
    beat("t2g", 1, 32'hB002, 2'b00, 0, 1, 1, 32'h108, 1);
    beat("t2h", 1, 32'hB003, 2'b00, 1, 0, 1, 32'h10C, 0);
    beat("t2i", 1, 32'hB003, 2'b00, 1, 1, 1, 32'h10C, 1);
    end_burst("t2", 0, 4);

    // 3: SLVERR on beat 5 of 8
    start_burst("t3", 32'h200, 8'd7, 0);
    for (int i = 0; i < 8; i++)
      beat($sformatf("t3_b%0d", i), 1, 32'h3000 + 32'(i), (i == 5) ? 2'b10 : 2'b00, i == 7, 1, 1,
           32'h200 + 32'(4 * i), 1);
    end_burst("t3", 1, 8);

    // 4a: early rlast (start also checks error cleared)
    start_burst("t4a", 32'h300, 8'd3, 0);
    beat("t4a_b0", 1, 32'h4000, 2'b00, 0, 1, 1, 32'h300, 1);
    beat("t4a_b1", 1, 32'h4001, 2'b00, 1, 1, 1, 32'h304, 1);
    end_burst("t4a", 1, 2);

    // 4b: late rlast, extra beats dropped even with m_ready low
    start_burst("t4b", 32'h400, 8'd1, 0);
    beat("t4b_b0", 1, 32'h5000, 2'b00, 0, 1, 1, 32'h400, 1);
    beat("t4b_b1", 1, 32'h5001, 2'b00, 0, 1, 1, 32'h404, 1);
    beat("t4b_ov2", 1, 32'h5002, 2'b00, 0, 0, 0, 32'h0, 1);
    beat("t4b_ov3", 1, 32'h5003, 2'b00, 1, 1, 0, 32'h0, 1);
    end_burst("t4b", 1, 2);

    // 5a: single beat, arready delayed 10 cycles
    start_burst("t5a", 32'h500, 8'd0, 10);
    beat("t5a_b0", 1, 32'h6000, 2'b00, 1, 1, 1, 32'h500, 1);
    end_burst("t5a", 0, 1);

    // 5b: address wraps past top of space
    start_burst("t5b", 32'hFFFF_FFFC, 8'd1, 0);
    beat("t5b_b0", 1, 32'h7000, 2'b00, 0, 1, 1, 32'hFFFF_FFFC, 1);
    beat("t5b_b1", 1, 32'h7001, 2'b00, 1, 1, 1, 32'h0000_0000, 1);
    end_burst("t5b", 0, 2);

    // 6: asynchronous reset mid-burst at beat 2
    start_burst("t6", 32'h600, 8'd3, 0);
    beat("t6_b0", 1, 32'h8000, 2'b10, 0, 1, 1, 32'h600, 1);
    beat("t6_b1", 1, 32'h8001, 2'b00, 0, 1, 1, 32'h604, 1);
    bus.m_axi_rvalid = 1'b1; bus.m_axi_rdata = 32'h8002; bus.m_ready = 1'b1;
    @(negedge clk);
    chk("t6_pre_mvalid", bus.m_valid, 1);
    chk("t6_pre_maddr", bus.m_addr, 32'h608);
    chk("t6_pre_error", bus.error, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", bus.ready, 1);
    chk("t6_rst_arvalid", bus.m_axi_arvalid, 0);
    chk("t6_rst_rready", bus.m_axi_rready, 0);
    chk("t6_rst_mvalid", bus.m_valid, 0);
    chk("t6_rst_error", bus.error, 0);
    #1 rst_n = 1'b1;
    bus.m_axi_rvalid = 1'b0; bus.m_ready = 1'b0;
    step();
    start_burst("t6c", 32'h700, 8'd0, 0);
    beat("t6c_b0", 1, 32'h9000, 2'b00, 1, 1, 1, 32'h700, 1);
    end_burst("t6c", 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
